alu_seq_nbits: RTL and testbench

Parametrised, handshaked successor to the 8-bit combinational ALU. Result and flags are registered.
- Single-cycle ops complete in one cycle.
- Unsigned multiply (and optionally divide/remainder) runs iteratively, one bit per cycle.
- Sits between the operand-fetch stage and writeback of the course datapath; a valid/ready pair on each side replaces the purely combinational interface.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_iter_muldiv.sv | 110 +++++++++++
 rtl/alu_seq_nbits.sv | 204 ++++++++++++++++++++
 tb/tb_alu_seq_nbits.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag-vector bit positions for alu_seq_nbits.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_ZF   = 0;
    localparam int unsigned FLAG_SF   = 1;
    localparam int unsigned FLAG_OF   = 2;
    localparam int unsigned FLAG_CF   = 3;
    localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier, plus a restoring divider when ALU_DIV_EN is defined.
// The start cycle performs the first bit, so all WIDTH bits are finished when done rises.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi,
    output logic             done
);

    localparam int unsigned CNTW = $clog2(WIDTH);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] src_acc, src_mq, src_dvs;
    logic [WIDTH:0]   sum_c;
    logic             step_c;
`ifdef ALU_DIV_EN
    logic             div_q, div_d, src_div;
    logic [WIDTH:0]   shl_c, dif_c;
`else
    logic             unused_op_div;
    assign unused_op_div = op_div;
`endif

    // acc holds product-high / partial remainder, mq holds multiplier / dividend-quotient
    always_comb begin
        src_acc = start ? '0 : acc_q;
        src_mq  = start ? a  : mq_q;
        src_dvs = start ? b  : dvs_q;
        step_c  = start || (busy_q && (cnt_q != '0));
        sum_c   = {1'b0, src_acc} + (src_mq[0] ? {1'b0, src_dvs} : '0);
        acc_d   = acc_q;
        mq_d    = mq_q;
        dvs_d   = src_dvs;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
`ifdef ALU_DIV_EN
        src_div = start ? op_div : div_q;
        div_d   = src_div;
        shl_c   = {src_acc, src_mq[WIDTH-1]};
        dif_c   = shl_c - {1'b0, src_dvs};
`endif
        if (step_c) begin
            acc_d = sum_c[WIDTH:1];
            mq_d  = {sum_c[0], src_mq[WIDTH-1:1]};
`ifdef ALU_DIV_EN
            if (src_div) begin
                if (!dif_c[WIDTH]) begin
                    {acc_d, mq_d} = {dif_c[WIDTH-1:0], src_mq[WIDTH-2:0], 1'b1};
                end else begin
                    {acc_d, mq_d} = {shl_c[WIDTH-1:0], src_mq[WIDTH-2:0], 1'b0};
                end
            end
`endif
        end
        if (start) begin
            cnt_d  = CNTW'(WIDTH - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNTW'(1);
            end else begin
                busy_d = 1'b0;
            end
        end
        done_d = busy_d && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            mq_q   <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else begin
            acc_q  <= acc_d;
            mq_q   <= mq_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
`ifdef ALU_DIV_EN
            div_q  <= div_d;
`endif
        end
    end

    assign lo   = mq_q;
    assign hi   = acc_q;
    assign done = done_q;

endmodule

// File: rtl/alu_seq_nbits.sv
// Handshaked WIDTH-bit ALU with registered result/flags; MUL (and DIVU/REMU under ALU_DIV_EN)
// run iteratively in alu_iter_muldiv, everything else completes in a single cycle.
module alu_seq_nbits
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       aluop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_res,
    output logic             ZF,
    output logic             SF,
    output logic             OF,
    output logic             CF
);

    localparam int unsigned   SHW     = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [NUM_FLAGS-1:0] flags_q, flags_d;
    logic [3:0]           op_q, op_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic                 accept_c, iter_op_c, start_c;
    logic [WIDTH-1:0]     sc_res_c, it_res_c, md_lo, md_hi;
    logic                 sc_of_c, sc_cf_c, it_cf_c, md_done;
    logic [WIDTH:0]       add_c, sub_c;
`ifdef ALU_DIV_EN
    logic                 div0_q, div0_d;
`endif

    function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic [WIDTH-1:0] r,
                                                        input logic of, input logic cf);
        logic [NUM_FLAGS-1:0] f;
        f          = '0;
        f[FLAG_ZF] = (r == '0);
        f[FLAG_SF] = r[WIDTH-1];
        f[FLAG_OF] = of;
        f[FLAG_CF] = cf;
        return f;
    endfunction

    // single-cycle datapath, evaluated on the live operands at the accept edge
    always_comb begin
        add_c    = {1'b0, A} + {1'b0, B};
        sub_c    = {1'b0, A} - {1'b0, B};
        sc_res_c = '0;
        sc_of_c  = 1'b0;
        sc_cf_c  = 1'b0;
        case (aluop)
            OP_ADD: begin
                sc_res_c = add_c[WIDTH-1:0];
                sc_cf_c  = add_c[WIDTH];
                sc_of_c  = (A[WIDTH-1] == B[WIDTH-1]) && (add_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res_c = sub_c[WIDTH-1:0];
                sc_cf_c  = sub_c[WIDTH];
                sc_of_c  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_c[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  sc_res_c = A & B;
            OP_OR:   sc_res_c = A | B;
            OP_NOT:  sc_res_c = ~A;
            OP_XOR:  sc_res_c = A ^ B;
            OP_SLL:  sc_res_c = (B >= WIDTH_V) ? '0 : (A << B[SHW-1:0]);
            OP_SRL:  sc_res_c = (B >= WIDTH_V) ? '0 : (A >> B[SHW-1:0]);
            OP_SRA:  sc_res_c = (B >= WIDTH_V) ? {WIDTH{A[WIDTH-1]}}
                                               : WIDTH'($signed(A) >>> B[SHW-1:0]);
            OP_SLT:  sc_res_c = WIDTH'($signed(A) < $signed(B));
            OP_SLTU: sc_res_c = WIDTH'(A < B);
            default: sc_res_c = '0;
        endcase
    end

    // result selection once the iterative unit finishes
    always_comb begin
        it_res_c = '0;
        it_cf_c  = 1'b0;
        case (op_q)
            OP_MUL: begin
                it_res_c = md_lo;
                it_cf_c  = |md_hi;
            end
`ifdef ALU_DIV_EN
            OP_DIVU: begin
                it_res_c = md_lo;
                it_cf_c  = div0_q;
            end
            OP_REMU: begin
                it_res_c = md_hi;
                it_cf_c  = div0_q;
            end
`endif
            default: it_res_c = '0;
        endcase
    end

`ifdef ALU_DIV_EN
    assign iter_op_c = (aluop == OP_MUL) || (aluop == OP_DIVU) || (aluop == OP_REMU);
`else
    assign iter_op_c = (aluop == OP_MUL);
`endif

    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        flags_d  = flags_q;
        op_d     = op_q;
        start_c  = 1'b0;
`ifdef ALU_DIV_EN
        div0_d   = div0_q;
`endif
        accept_c = in_valid && in_ready_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    op_d = aluop;
                    if (iter_op_c) begin
                        state_d = S_BUSY;
                        start_c = 1'b1;
`ifdef ALU_DIV_EN
                        div0_d  = (B == '0);
`endif
                    end else begin
                        state_d = S_DONE;
                        res_d   = sc_res_c;
                        flags_d = pack_flags(sc_res_c, sc_of_c, sc_cf_c);
                    end
                end
            end
            S_BUSY: begin
                if (md_done) begin
                    state_d = S_DONE;
                    res_d   = it_res_c;
                    flags_d = pack_flags(it_res_c, 1'b0, it_cf_c);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            res_q       <= '0;
            flags_q     <= '0;
            op_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ALU_DIV_EN
            div0_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            op_q        <= op_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef ALU_DIV_EN
            div0_q      <= div0_d;
`endif
        end
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .op_div ((aluop == OP_DIVU) || (aluop == OP_REMU)),
        .a      (A),
        .b      (B),
        .lo     (md_lo),
        .hi     (md_hi),
        .done   (md_done)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign alu_res   = res_q;
    assign ZF        = flags_q[FLAG_ZF];
    assign SF        = flags_q[FLAG_SF];
    assign OF        = flags_q[FLAG_OF];
    assign CF        = flags_q[FLAG_CF];

endmodule

// File: tb/tb_alu_seq_nbits.sv
// Table-driven bench for alu_seq_nbits (WIDTH=8) with a scoreboard queue; expectations follow ALU_DIV_EN.
module tb_alu_seq_nbits;

    localparam int unsigned W = 8;

    localparam logic [3:0] O_ADD  = 4'h0;
    localparam logic [3:0] O_SUB  = 4'h1;
    localparam logic [3:0] O_AND  = 4'h2;
    localparam logic [3:0] O_OR   = 4'h3;
    localparam logic [3:0] O_NOT  = 4'h4;
    localparam logic [3:0] O_XOR  = 4'h5;
    localparam logic [3:0] O_SLL  = 4'h6;
    localparam logic [3:0] O_SRL  = 4'h7;
    localparam logic [3:0] O_SRA  = 4'h8;
    localparam logic [3:0] O_SLT  = 4'h9;
    localparam logic [3:0] O_SLTU = 4'hA;
    localparam logic [3:0] O_MUL  = 4'hB;
    localparam logic [3:0] O_DIVU = 4'hC;
    localparam logic [3:0] O_REMU = 4'hD;

    // expected flags packed as {CF, OF, SF, ZF}
    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]  flags;
        int unsigned lat;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [3:0]   aluop;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_res;
    logic         ZF, SF, OF, CF;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    vec_t        sb[$];
    vec_t        tbl[$];

    alu_seq_nbits #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .aluop     (aluop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_res   (alu_res),
        .ZF        (ZF),
        .SF        (SF),
        .OF        (OF),
        .CF        (CF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input string name, input logic [3:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] res,
                                input logic [3:0] flags, input int unsigned lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b;
        v.res = res; v.flags = flags; v.lat = lat;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // drive one request, wait for the result, compare against the scoreboard head
    task automatic run_vec(input vec_t v);
        int unsigned lat;
        bit          ready_low;
        vec_t        e;
        @(negedge clk);
        cmp({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        A         = v.a;
        B         = v.b;
        aluop     = v.op;
        out_ready = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        lat       = 0;
        ready_low = 1'b1;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            A        = W'($urandom);
            B        = W'($urandom);
            aluop    = 4'($urandom);
            lat++;
            if (!out_valid && in_ready) ready_low = 1'b0;
        end while (!out_valid && lat < 40);
        cmp({v.name, ".latency"}, 32'(lat), 32'(v.lat));
        if (v.lat > 1) cmp({v.name, ".busy_in_ready0"}, 32'(ready_low), 32'd1);
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.scoreboard: got empty queue, want an entry", v.name);
        end else begin
            e = sb.pop_front();
            cmp({e.name, ".res"}, 32'(alu_res), 32'(e.res));
            cmp({e.name, ".flags"}, 32'({CF, OF, SF, ZF}), 32'(e.flags));
        end
    endtask

    initial begin
        vec_t e;
        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        aluop     = '0;
        out_ready = 1'b0;
        #3;
        cmp("reset.in_ready", 32'(in_ready), 32'd1);
        cmp("reset.out_valid", 32'(out_valid), 32'd0);
        cmp("reset.res", 32'(alu_res), 32'd0);
        cmp("reset.flags", 32'({CF, OF, SF, ZF}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back(mk("add_ovf",   O_ADD,  8'h78, 8'h08, 8'h80, 4'b0110, 1));
        tbl.push_back(mk("add_carry", O_ADD,  8'hFA, 8'h06, 8'h00, 4'b1001, 1));
        tbl.push_back(mk("add_7f",    O_ADD,  8'h7F, 8'h01, 8'h80, 4'b0110, 1));
        tbl.push_back(mk("sub_borrow",O_SUB,  8'hFA, 8'hFB, 8'hFF, 4'b1010, 1));
        tbl.push_back(mk("sub_ovf",   O_SUB,  8'h80, 8'h01, 8'h7F, 4'b0100, 1));
        tbl.push_back(mk("and",       O_AND,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1));
        tbl.push_back(mk("or",        O_OR,   8'hF0, 8'h0C, 8'hFC, 4'b0010, 1));
        tbl.push_back(mk("not",       O_NOT,  8'h5A, 8'h00, 8'hA5, 4'b0010, 1));
        tbl.push_back(mk("xor",       O_XOR,  8'hFF, 8'hFF, 8'h00, 4'b0001, 1));
        tbl.push_back(mk("sll7",      O_SLL,  8'h01, 8'h07, 8'h80, 4'b0010, 1));
        tbl.push_back(mk("sll9",      O_SLL,  8'h78, 8'h09, 8'h00, 4'b0001, 1));
        tbl.push_back(mk("srl7",      O_SRL,  8'h80, 8'h07, 8'h01, 4'b0000, 1));
        tbl.push_back(mk("srl_big",   O_SRL,  8'hF0, 8'hC8, 8'h00, 4'b0001, 1));
        tbl.push_back(mk("sra3",      O_SRA,  8'h88, 8'h03, 8'hF1, 4'b0010, 1));
        tbl.push_back(mk("sra8",      O_SRA,  8'h80, 8'h08, 8'hFF, 4'b0010, 1));
        tbl.push_back(mk("slt_neg",   O_SLT,  8'h88, 8'hF8, 8'h01, 4'b0000, 1));
        tbl.push_back(mk("slt_false", O_SLT,  8'h7F, 8'h80, 8'h00, 4'b0001, 1));
        tbl.push_back(mk("sltu",      O_SLTU, 8'hFA, 8'hFB, 8'h01, 4'b0000, 1));
        tbl.push_back(mk("sltu_7f",   O_SLTU, 8'h7F, 8'h80, 8'h01, 4'b0000, 1));
        tbl.push_back(mk("illegal_e", 4'hE,   8'hFF, 8'hFF, 8'h00, 4'b0001, 1));
        tbl.push_back(mk("illegal_f", 4'hF,   8'h12, 8'h34, 8'h00, 4'b0001, 1));
        tbl.push_back(mk("mul_ff",    O_MUL,  8'h0F, 8'h11, 8'hFF, 4'b0010, 9));
        tbl.push_back(mk("mul_100",   O_MUL,  8'h10, 8'h10, 8'h00, 4'b1001, 9));
        tbl.push_back(mk("mul_fe01",  O_MUL,  8'hFF, 8'hFF, 8'h01, 4'b1000, 9));
`ifdef ALU_DIV_EN
        tbl.push_back(mk("divu",      O_DIVU, 8'hFA, 8'h07, 8'h23, 4'b0000, 9));
        tbl.push_back(mk("remu",      O_REMU, 8'hFA, 8'h07, 8'h05, 4'b0000, 9));
        tbl.push_back(mk("divu_z",    O_DIVU, 8'h12, 8'h00, 8'hFF, 4'b1010, 9));
        tbl.push_back(mk("remu_z",    O_REMU, 8'h12, 8'h00, 8'h12, 4'b1000, 9));
        tbl.push_back(mk("divu_small",O_DIVU, 8'h07, 8'hFA, 8'h00, 4'b0001, 9));
        tbl.push_back(mk("remu_small",O_REMU, 8'h07, 8'hFA, 8'h07, 4'b0000, 9));
`else
        tbl.push_back(mk("divu_off",  O_DIVU, 8'hFA, 8'h07, 8'h00, 4'b0001, 1));
        tbl.push_back(mk("remu_off",  O_REMU, 8'hFA, 8'h07, 8'h00, 4'b0001, 1));
`endif
        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // backpressure: result held while out_ready is low, new requests ignored
        @(negedge clk);
        in_valid  = 1'b1;
        A         = 8'h40;
        B         = 8'h40;
        aluop     = O_ADD;
        out_ready = 1'b0;
        sb.push_back(mk("bp_add", O_ADD, 8'h40, 8'h40, 8'h80, 4'b0110, 1));
        @(negedge clk);
        cmp("bp.out_valid", 32'(out_valid), 32'd1);
        A     = 8'h01;
        B     = 8'h02;
        aluop = O_SUB;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cmp("bp.hold_res", 32'(alu_res), 32'h80);
            cmp("bp.hold_flags", 32'({CF, OF, SF, ZF}), 32'b0110);
            cmp("bp.hold_in_ready", 32'(in_ready), 32'd0);
            cmp("bp.hold_out_valid", 32'(out_valid), 32'd1);
        end
        e = sb.pop_front();
        cmp({e.name, ".res"}, 32'(alu_res), 32'(e.res));
        cmp({e.name, ".flags"}, 32'({CF, OF, SF, ZF}), 32'(e.flags));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        cmp("bp.release_out_valid", 32'(out_valid), 32'd0);
        cmp("bp.release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        cmp("bp.no_ghost_op", 32'(out_valid), 32'd0);

        // reset asserted in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        A        = 8'h0F;
        B        = 8'h11;
        aluop    = O_MUL;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst.busy_in_ready", 32'(in_ready), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        cmp("rst.out_valid", 32'(out_valid), 32'd0);
        cmp("rst.in_ready", 32'(in_ready), 32'd1);
        cmp("rst.res", 32'(alu_res), 32'd0);
        cmp("rst.flags", 32'({CF, OF, SF, ZF}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(mk("post_rst_add", O_ADD, 8'h01, 8'h01, 8'h02, 4'b0000, 1));
        run_vec(mk("post_rst_mul", O_MUL, 8'h03, 8'h05, 8'h0F, 4'b0000, 9));

        cmp("scoreboard.empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
